branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Gshare dynamic branch predictor supplying the fetch-stage taken prediction (pc_src_pred_f) consumed by the branch control unit.
- Holds a table of 2-bit saturating counters indexed by PC XOR speculative global history register (GHR).
- Updates speculatively in F and is trained/repaired when branches resolve in E.
- Also keeps branch and mispredict counters for performance visibility.

Parameters:
- INDEX_WIDTH, 6, log2 of pattern-table entries (64 entries).
- GHR_WIDTH, 6, global history bits; must satisfy 1 <= GHR_WIDTH <= INDEX_WIDTH.
- STAT_WIDTH, 32, width of the performance counters.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- stall_f_i  in  1  fetch stage stalled
- pc_f_i  in  32  fetch PC
- op_f_i  in  2  fetch opcode class; 2'b11 = branch/jump class
- branch_e_i  in  1  conditional branch resolving in E this cycle (already qualified by E-stage valid)
- pc_e_i  in  32  PC of the E-stage instruction
- ghr_e_i  in  GHR_WIDTH  history snapshot carried with the E instruction
- pc_src_pred_e_i  in  1  prediction carried with the E instruction
- pc_src_res_e_i  in  1  resolved direction (1 = taken)
- pc_src_pred_f_o  out  1  predicted taken for the F instruction
- ghr_f_o  out  GHR_WIDTH  history snapshot for the F instruction, to be piped to E
- mispredict_e_o  out  1  branch_e_i & (pc_src_pred_e_i != pc_src_res_e_i)
- branch_count_o  out  STAT_WIDTH  resolved conditional branches
- mispredict_count_o  out  STAT_WIDTH  resolved mispredictions

Behaviour:
- Reset: on clk_i edge with reset_i=1:
  - every counter <= 2'b01 (weakly not-taken);
  - GHR <= 0;
  - both stat counters <= 0.
  - Hence pc_src_pred_f_o = 0 and ghr_f_o = 0 the cycle after reset.
  - reset_i dominates every other input.
- Index widths: GHR zero-extended to INDEX_WIDTH.
  - idx_f = pc_f_i[INDEX_WIDTH+1:2] ^ GHR
  - idx_e = pc_e_i[INDEX_WIDTH+1:2] ^ ghr_e_i
- Prediction: combinational, zero latency.
  - pc_src_pred_f_o = table[idx_f][1] & (op_f_i == 2'b11).
  - ghr_f_o = current GHR.
- Speculative history: on a clock edge with op_f_i==2'b11, !stall_f_i and no mispredict_e_o, GHR <= {GHR[GHR_WIDTH-2:0], pc_src_pred_f_o}.
  - When GHR_WIDTH == 1, GHR <= pc_src_pred_f_o.
  - If stalled, GHR holds.
- Repair: when mispredict_e_o=1, GHR <= {ghr_e_i[GHR_WIDTH-2:0], pc_src_res_e_i}.
  - Repair has priority over the speculative shift in the same cycle, since the F instruction is flushed.
- Training: when branch_e_i=1, table[idx_e] steps toward pc_src_res_e_i.
  - Taken: increment, saturating at 2'b11.
  - Not taken: decrement, saturating at 2'b00.
  - Only entry idx_e changes.
- Same-index read/write in one cycle (idx_f == idx_e): the prediction uses the pre-update value; there is no bypass.
- Stats:
  - branch_count_o increments on branch_e_i.
  - mispredict_count_o increments on mispredict_e_o.
  - Both saturate at all-ones (no wrap).
- Non-branch E instructions (branch_e_i=0) alter no state.
- Reset asserted mid-operation: in-flight snapshots are discarded; the pipeline flush is the control unit's responsibility.

Decomposition:
- Shared control package additions:
  - 2-bit counter encodings CNT_SNT=00, CNT_WNT=01, CNT_WT=10, CNT_ST=11;
  - opcode class constant for branch (2'b11);
  - default INDEX_WIDTH/GHR_WIDTH.
- One natural sub-module: sat_counter_2b, a pure next-state function (cur, taken -> next).
- Table, GHR and stats stay in branch_predictor.

Test Plan:
- Reset, then pc_f_i=0x100, op_f_i=11 -> pc_src_pred_f_o=0, ghr_f_o=0; all counts 0.
- Train pc_e_i=0x100, ghr_e_i=0, taken, twice -> entry idx 0x00 goes 01→10→11; next F fetch at 0x100 with GHR=0 predicts 1. Three not-taken trainings -> 11→10→01→00; a fourth holds at 00.
- Speculative shift with GHR_WIDTH=6: three unstalled branch fetches predicting 1,0,1 -> GHR=6'b000101. Assert stall_f_i during a fourth fetch -> GHR stays 000101.
- Mispredict repair and priority: GHR=6'b000101; same cycle, F branch fetch plus E branch with ghr_e_i=6'b000010, pred=1, res=0 -> mispredict_e_o=1, GHR=6'b000100 (not the shifted value), mispredict_count_o=1, branch_count_o=1.
- Same-index conflict: idx_f==idx_e, entry=01, E trains taken -> pc_src_pred_f_o=0 that cycle, 1 the next cycle.
- Saturation: STAT_WIDTH=4, 20 mispredicting resolutions -> both counters read 4'hF. Then assert reset_i -> both 0 and the table returns to 01 on the next cycle.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the gshare branch predictor: counter encodings,
// the branch opcode class and default table/history/statistics sizes.
package branch_predictor_pkg;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam logic [1:0] OP_BRANCH = 2'b11;

  localparam int DEFAULT_INDEX_WIDTH = 6;
  localparam int DEFAULT_GHR_WIDTH   = 6;
  localparam int DEFAULT_STAT_WIDTH  = 32;

endpackage

// File: rtl/branch_predictor_sat_counter_2b.sv
// 2-bit saturating counter next-state function (cur, taken -> next).
// Purely combinational, zero latency, no flow control.
module sat_counter_2b
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur_i,
  input  logic       taken_i,
  output logic [1:0] next_o
);

  always_comb begin
    next_o = cur_i;
    if (taken_i) begin
      if (cur_i != CNT_ST) next_o = cur_i + 2'd1;
    end else begin
      if (cur_i != CNT_SNT) next_o = cur_i - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Gshare predictor: PC^GHR-indexed 2-bit counters, speculative GHR with E-stage repair.
// Prediction is combinational (zero latency); no backpressure, stall_f_i only freezes history.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int GHR_WIDTH   = DEFAULT_GHR_WIDTH,
  parameter int STAT_WIDTH  = DEFAULT_STAT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  stall_f_i,
  input  logic [31:0]           pc_f_i,
  input  logic [1:0]            op_f_i,
  input  logic                  branch_e_i,
  input  logic [31:0]           pc_e_i,
  input  logic [GHR_WIDTH-1:0]  ghr_e_i,
  input  logic                  pc_src_pred_e_i,
  input  logic                  pc_src_res_e_i,
  output logic                  pc_src_pred_f_o,
  output logic [GHR_WIDTH-1:0]  ghr_f_o,
  output logic                  mispredict_e_o,
  output logic [STAT_WIDTH-1:0] branch_count_o,
  output logic [STAT_WIDTH-1:0] mispredict_count_o
);

  localparam int ENTRIES = 1 << INDEX_WIDTH;

  logic [1:0]             pht_q [ENTRIES];
  logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;
  logic [STAT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
  logic [STAT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;
  logic [INDEX_WIDTH-1:0] idx_f, idx_e;
  logic [1:0]             cnt_e_next;
  logic                   is_branch_f;
  logic                   unused_pc_bits;

  // Shift a new outcome into the youngest history bit; also valid for GHR_WIDTH == 1.
  function automatic logic [GHR_WIDTH-1:0] hist_push(input logic [GHR_WIDTH-1:0] h,
                                                     input logic               b);
    logic [GHR_WIDTH:0] t;
    t = {h, b};
    return t[GHR_WIDTH-1:0];
  endfunction

  assign idx_f = pc_f_i[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr_q);
  assign idx_e = pc_e_i[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr_e_i);

  assign unused_pc_bits = ^{pc_f_i[31:INDEX_WIDTH+2], pc_f_i[1:0],
                            pc_e_i[31:INDEX_WIDTH+2], pc_e_i[1:0]};

  assign is_branch_f        = (op_f_i == OP_BRANCH);
  assign pc_src_pred_f_o    = pht_q[idx_f][1] & is_branch_f;
  assign ghr_f_o            = ghr_q;
  assign mispredict_e_o     = branch_e_i & (pc_src_pred_e_i != pc_src_res_e_i);
  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = mispred_cnt_q;

  sat_counter_2b u_sat_counter (
    .cur_i   (pht_q[idx_e]),
    .taken_i (pc_src_res_e_i),
    .next_o  (cnt_e_next)
  );

  // A mispredict flushes the F instruction, so repair wins over the speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (mispredict_e_o) begin
      ghr_d = hist_push(ghr_e_i, pc_src_res_e_i);
    end else if (is_branch_f && !stall_f_i) begin
      ghr_d = hist_push(ghr_q, pc_src_pred_f_o);
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (branch_e_i && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + STAT_WIDTH'(1);
    end
    if (mispredict_e_o && (mispred_cnt_q != '1)) begin
      mispred_cnt_d = mispred_cnt_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pht_q[i] <= CNT_WNT;
      end
      ghr_q         <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (branch_e_i) begin
        pht_q[idx_e] <= cnt_e_next;
      end
      ghr_q         <= ghr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus randomized traffic
// checked against an arithmetic gshare reference model.
module tb_branch_predictor;

  localparam int IW       = 6;
  localparam int GW       = 6;
  localparam int SW       = 4;
  localparam int STAT_MAX = (1 << SW) - 1;
  localparam int N_ENT    = 1 << IW;
  localparam int GMOD     = 1 << GW;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          stall_f_i = 1'b0;
  logic [31:0]   pc_f_i = '0;
  logic [1:0]    op_f_i = '0;
  logic          branch_e_i = 1'b0;
  logic [31:0]   pc_e_i = '0;
  logic [GW-1:0] ghr_e_i = '0;
  logic          pc_src_pred_e_i = 1'b0;
  logic          pc_src_res_e_i = 1'b0;
  logic          pc_src_pred_f_o;
  logic [GW-1:0] ghr_f_o;
  logic          mispredict_e_o;
  logic [SW-1:0] branch_count_o;
  logic [SW-1:0] mispredict_count_o;

  always #5 clk_i = ~clk_i;

  branch_predictor #(
    .INDEX_WIDTH (IW),
    .GHR_WIDTH   (GW),
    .STAT_WIDTH  (SW)
  ) dut (
    .clk_i              (clk_i),
    .reset_i            (reset_i),
    .stall_f_i          (stall_f_i),
    .pc_f_i             (pc_f_i),
    .op_f_i             (op_f_i),
    .branch_e_i         (branch_e_i),
    .pc_e_i             (pc_e_i),
    .ghr_e_i            (ghr_e_i),
    .pc_src_pred_e_i    (pc_src_pred_e_i),
    .pc_src_res_e_i     (pc_src_res_e_i),
    .pc_src_pred_f_o    (pc_src_pred_f_o),
    .ghr_f_o            (ghr_f_o),
    .mispredict_e_o     (mispredict_e_o),
    .branch_count_o     (branch_count_o),
    .mispredict_count_o (mispredict_count_o)
  );

  typedef struct {
    int step;
    int pred;
    int ghr;
    int mis;
    int bc;
    int mc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   step  = 0;

  // Reference model: counters as integers 0..3, history as an integer modulo 2^GW.
  int pht_m[N_ENT];
  int ghr_m = 0;
  int bc_m  = 0;
  int mc_m  = 0;
  bit m_valid = 1'b0;

  task automatic chk(input string name, input int stp, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, stp, got, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit stall, input logic [31:0] pcf,
                       input logic [1:0] op, input bit br, input logic [31:0] pce,
                       input int ghe, input bit pe, input bit re);
    exp_t e;
    int   idx_f, idx_e, pred, mis;
    @(negedge clk_i);
    reset_i         = rst;
    stall_f_i       = stall;
    pc_f_i          = pcf;
    op_f_i          = op;
    branch_e_i      = br;
    pc_e_i          = pce;
    ghr_e_i         = GW'(ghe);
    pc_src_pred_e_i = pe;
    pc_src_res_e_i  = re;
    #1;
    step++;
    idx_f = ((int'(pcf) >> 2) % N_ENT) ^ ghr_m;
    pred  = (op == 2'b11 && pht_m[idx_f] >= 2) ? 1 : 0;
    mis   = (br && (pe != re)) ? 1 : 0;
    if (!rst && m_valid) begin
      e.step = step; e.pred = pred; e.ghr = ghr_m; e.mis = mis;
      e.bc = bc_m; e.mc = mc_m;
      exp_q.push_back(e);
    end
    if (rst) begin
      for (int i = 0; i < N_ENT; i++) pht_m[i] = 1;
      ghr_m   = 0;
      bc_m    = 0;
      mc_m    = 0;
      m_valid = 1'b1;
    end else begin
      if (br) begin
        idx_e = ((int'(pce) >> 2) % N_ENT) ^ (ghe % GMOD);
        if (re) pht_m[idx_e] = (pht_m[idx_e] < 3) ? pht_m[idx_e] + 1 : 3;
        else    pht_m[idx_e] = (pht_m[idx_e] > 0) ? pht_m[idx_e] - 1 : 0;
        if (bc_m < STAT_MAX) bc_m++;
        if (mis && mc_m < STAT_MAX) mc_m++;
      end
      if (mis)                      ghr_m = ((ghe % GMOD) * 2 + (re ? 1 : 0)) % GMOD;
      else if (op == 2'b11 && !stall) ghr_m = (ghr_m * 2 + pred) % GMOD;
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input bit stall);
    cycle(1'b0, stall, pc, 2'b11, 1'b0, 32'h0, 0, 1'b0, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input int ghe, input bit pe, input bit re);
    cycle(1'b0, 1'b0, 32'h0, 2'b00, 1'b1, pc, ghe, pe, re);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are valid every cycle, sampled well after the driving edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pred", e.step, int'(pc_src_pred_f_o), e.pred);
        chk("sb_ghr",  e.step, int'(ghr_f_o),         e.ghr);
        chk("sb_mis",  e.step, int'(mispredict_e_o),  e.mis);
        chk("sb_bcnt", e.step, int'(branch_count_o),  e.bc);
        chk("sb_mcnt", e.step, int'(mispredict_count_o), e.mc);
      end
    end
  end

  initial begin
    cycle(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 0, 1'b0, 1'b0);

    fetch(32'h100, 1'b0);
    #1 chk("rst_pred", step, int'(pc_src_pred_f_o), 0);
    chk("rst_ghr",  step, int'(ghr_f_o), 0);
    chk("rst_bcnt", step, int'(branch_count_o), 0);
    chk("rst_mcnt", step, int'(mispredict_count_o), 0);

    train(32'h100, 0, 1'b1, 1'b1);
    train(32'h100, 0, 1'b1, 1'b1);
    fetch(32'h100, 1'b1);
    #1 chk("train_t_pred", step, int'(pc_src_pred_f_o), 1);

    repeat (4) train(32'h100, 0, 1'b0, 1'b0);
    train(32'h100, 0, 1'b1, 1'b1);
    fetch(32'h100, 1'b1);
    #1 chk("sat_low_pred", step, int'(pc_src_pred_f_o), 0);

    train(32'h104, 0, 1'b1, 1'b1);
    train(32'h104, 0, 1'b1, 1'b1);
    train(32'h114, 0, 1'b1, 1'b1);
    train(32'h114, 0, 1'b1, 1'b1);
    fetch(32'h104, 1'b0);
    #1 chk("spec_p1", step, int'(pc_src_pred_f_o), 1);
    fetch(32'h108, 1'b0);
    #1 chk("spec_p2", step, int'(pc_src_pred_f_o), 0);
    fetch(32'h11C, 1'b0);
    #1 chk("spec_p3", step, int'(pc_src_pred_f_o), 1);
    fetch(32'h104, 1'b1);
    #1 chk("spec_ghr", step, int'(ghr_f_o), 5);
    idle();
    #1 chk("stall_ghr", step, int'(ghr_f_o), 5);

    cycle(1'b0, 1'b0, 32'h104, 2'b11, 1'b1, 32'h300, 2, 1'b1, 1'b0);
    #1 chk("mis_flag", step, int'(mispredict_e_o), 1);
    idle();
    #1 chk("repair_ghr", step, int'(ghr_f_o), 4);
    chk("repair_mcnt", step, int'(mispredict_count_o), 1);
    chk("repair_bcnt", step, int'(branch_count_o), 12);

    cycle(1'b0, 1'b1, 32'h120, 2'b11, 1'b1, 32'h130, 0, 1'b1, 1'b1);
    #1 chk("conflict_old", step, int'(pc_src_pred_f_o), 0);
    fetch(32'h120, 1'b1);
    #1 chk("conflict_new", step, int'(pc_src_pred_f_o), 1);

    repeat (20) train(32'h1A0, 0, 1'b1, 1'b0);
    idle();
    #1 chk("sat_bcnt", step, int'(branch_count_o), STAT_MAX);
    chk("sat_mcnt", step, int'(mispredict_count_o), STAT_MAX);
    cycle(1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    fetch(32'h104, 1'b1);
    #1 chk("rst2_bcnt", step, int'(branch_count_o), 0);
    chk("rst2_mcnt", step, int'(mispredict_count_o), 0);
    chk("rst2_pred", step, int'(pc_src_pred_f_o), 0);
    train(32'h104, 0, 1'b1, 1'b1);
    fetch(32'h104, 1'b1);
    #1 chk("rst2_wnt", step, int'(pc_src_pred_f_o), 1);

    for (int n = 0; n < 800; n++) begin
      logic [31:0] pcf, pce;
      logic [1:0]  op;
      pcf = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 63)) << 2);
      pce = ($urandom & 32'hFFFF_0003) | (32'($urandom_range(0, 63)) << 2);
      op  = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 3));
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0, pcf, op,
            $urandom_range(0, 1) == 1, pce, $urandom_range(0, GMOD - 1),
            1'($urandom), 1'($urandom));
    end

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk_i);
    #5 chk("sb_drain", step, exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
